switch_press_classifier: RTL

SWITCH_PRESS_CLASSIFIER -- requirements
Module: switch_press_classifier

---
 rtl/switch_press_classifier.sv | 111 +++++++++++
 1 files changed

// File: rtl/switch_press_classifier.sv
// Classifies debounced switch presses as short, long or double, emitting a
// one-clock registered pulse per classification.
module switch_press_classifier #(
   parameter int unsigned CLKS_LONG       = 12500000,
   parameter int unsigned CLKS_DOUBLE_GAP = 6250000
) (
   input  logic i_Clk,
   input  logic i_Rst_L,
   input  logic i_Switch,
   output logic o_Short_Press,
   output logic o_Long_Press,
   output logic o_Double_Press,
   output logic o_Busy
);

   localparam int unsigned CLKS_MAX = (CLKS_LONG > CLKS_DOUBLE_GAP) ? CLKS_LONG : CLKS_DOUBLE_GAP;
   localparam int unsigned CNT_W    = $clog2(CLKS_MAX) + 1;

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(CLKS_LONG - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CLKS_DOUBLE_GAP - 1);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] PRESS1   = 2'd1;
   localparam logic [1:0] GAP      = 2'd2;
   localparam logic [1:0] WAIT_REL = 2'd3;

   logic [1:0]       r_State, state_nxt;
   logic [CNT_W-1:0] r_Count, count_nxt;
   logic             r_Switch;
   logic             r_Double_Pend, double_pend_nxt;
   logic             short_nxt, long_nxt, double_nxt, busy_nxt;
   logic             rise_c, fall_c;

   assign rise_c = i_Switch & ~r_Switch;
   assign fall_c = ~i_Switch & r_Switch;

   // Next-state, counter and pulse decisions.
   always_comb begin
      state_nxt       = r_State;
      count_nxt       = r_Count;
      short_nxt       = 1'b0;
      long_nxt        = 1'b0;
      double_pend_nxt = 1'b0;
      double_nxt      = r_Double_Pend;
      case (r_State)
         IDLE: begin
            if (rise_c) begin
               state_nxt = PRESS1;
               count_nxt = '0;
            end
         end
         PRESS1: begin
            if (fall_c) begin
               state_nxt = GAP;
               count_nxt = '0;
            end else if (r_Count == LONG_LAST) begin
               long_nxt  = 1'b1;
               state_nxt = WAIT_REL;
            end else begin
               count_nxt = r_Count + CNT_W'(1);
            end
         end
         GAP: begin
            // Timeout wins over a rise landing on the same cycle.
            if (r_Count == GAP_LAST) begin
               short_nxt = 1'b1;
               state_nxt = IDLE;
            end else if (rise_c) begin
               double_pend_nxt = 1'b1;
               state_nxt       = WAIT_REL;
            end else begin
               count_nxt = r_Count + CNT_W'(1);
            end
         end
         WAIT_REL: begin
            if (fall_c) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            count_nxt = '0;
         end
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   // State, counter, edge-detect and output registers.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         r_State        <= IDLE;
         r_Count        <= '0;
         r_Switch       <= 1'b1;
         r_Double_Pend  <= 1'b0;
         o_Short_Press  <= 1'b0;
         o_Long_Press   <= 1'b0;
         o_Double_Press <= 1'b0;
         o_Busy         <= 1'b0;
      end else begin
         r_State        <= state_nxt;
         r_Count        <= count_nxt;
         r_Switch       <= i_Switch;
         r_Double_Pend  <= double_pend_nxt;
         o_Short_Press  <= short_nxt;
         o_Long_Press   <= long_nxt;
         o_Double_Press <= double_nxt;
         o_Busy         <= busy_nxt;
      end
   end

endmodule
